atm_pin_entry: RTL and testbench
================================

ATM_PIN_ENTRY -- requirements
Module: atm_pin_entry

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, idle cycles allowed between accepted keys before the entry aborts.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 card_present  input  1  level; high while a card is inserted.
REQ-005 key_valid  input  1  one-cycle strobe qualifying key_code.
REQ-006 key_code  input  4  0x0-0x9 digit, 0xA clear, 0xB enter, 0xC cancel, 0xD-0xF reserved.
REQ-007 stored_pin  input  16  reference PIN, 4 BCD digits, first digit in [15:12]; stable while card_present.
REQ-008 pin_input  output  16  captured BCD digits, first digit in [15:12], unused digits 0.
REQ-009 digit_count  output  3  digits captured so far, 0-4.
REQ-010 pin_valid  output  1  one-cycle pulse; verdict available.
REQ-011 correct_pin  output  1  verdict level, held until card removal.
REQ-012 pin_error  output  1  one-cycle pulse; enter pressed with fewer than 4 digits.
REQ-013 abort  output  1  one-cycle pulse; cancel key or timeout.
REQ-014 busy  output  1  high in COLLECT and CHECK.

Function
REQ-015 FSM states SHALL be IDLE, COLLECT, CHECK, DONE, ABORTED; all outputs registered.
REQ-016 IDLE: card_present high -> COLLECT with buffer, digit_count and timer cleared.
REQ-017 COLLECT, digit key, digit_count<4: digit shifted into next BCD slot (first digit -> [15:12]), digit_count+1, timer cleared.
REQ-018 COLLECT, digit key, digit_count==4: key ignored, no state change, timer still cleared.
REQ-019 COLLECT, clear key: buffer and digit_count zeroed, stay COLLECT, timer cleared.
REQ-020 COLLECT, enter key, digit_count==4: -> CHECK; digit_count<4: pin_error pulse, buffer and count zeroed, stay COLLECT.
REQ-021 CHECK lasts exactly one cycle: correct_pin <= (pin_input == stored_pin), pin_valid pulsed, -> DONE; pin_valid/correct_pin visible on the second rising edge after the edge sampling enter.
REQ-022 DONE: all keys ignored; correct_pin and pin_input held; exit only via card removal.
REQ-023 COLLECT, cancel key: abort pulse, -> ABORTED; buffer and count zeroed.
REQ-024 Timer counts every COLLECT cycle without an accepted key; reaching TIMEOUT_CYCLES-1 -> abort pulse, -> ABORTED, buffer zeroed.
REQ-025 ABORTED: keys ignored; correct_pin 0; exit only via card removal.
REQ-026 card_present low in any state -> IDLE next edge; pin_input, digit_count, correct_pin cleared; no pulses; overrides a simultaneous key.
REQ-027 Reserved key codes and key_valid in IDLE are ignored without side effects.
REQ-028 pin_valid, pin_error, abort SHALL never be high in the same cycle and never longer than one cycle.
REQ-029 Timer width SHALL be ceil(log2(TIMEOUT_CYCLES))+1 bits; no wrap before timeout.

Reset
REQ-030 reset_n low: state IDLE; pin_input 0, digit_count 0, pin_valid 0, correct_pin 0, pin_error 0, abort 0, busy 0, timer 0.
REQ-031 Reset mid-entry discards captured digits; first edge after release samples card_present as from IDLE.

Structure
REQ-032 Shared ATM package SHALL hold state encodings, key-code constants (KEY_CLEAR, KEY_ENTER, KEY_CANCEL), PIN_DIGITS=4, TIMEOUT_CYCLES default.
REQ-033 One sub-module atm_key_timer (clearable inactivity counter, timeout pulse output) SHALL be instantiated; compare and shift logic stay in atm_pin_entry.

Verification
REQ-034 Card in, keys 1,2,3,4,enter, stored_pin 0x1234 -> pin_input 0x1234, pin_valid one pulse 2 edges after enter, correct_pin 1.
REQ-035 Keys 1,2,3,5,enter, stored_pin 0x1234 -> pin_valid pulse, correct_pin 0; card removal -> IDLE, all outputs 0.
REQ-036 Keys 9,8,enter -> pin_error pulse, digit_count 0, stays COLLECT; then 1,2,3,4,5,enter -> pin_input 0x1234, fifth digit ignored.
REQ-037 TIMEOUT_CYCLES=16, key 7 then no keys -> abort pulse 16 cycles later, ABORTED, pin_input 0; keys ignored until card removed.
REQ-038 Keys 1,2,clear,5,6,7,8,enter, stored_pin 0x5678 -> correct_pin 1; cancel in a fresh entry -> abort pulse, busy 0.
REQ-039 reset_n asserted after 2 digits, and card_present dropping same cycle as enter -> all outputs 0, no pin_valid.

Source files
------------

// File: rtl/atm_pin_entry_pkg.sv
// Shared ATM definitions: FSM encodings, keypad codes, PIN geometry and the
// BCD slot-placement helper used by the PIN entry block.
package atm_pin_entry_pkg;

  localparam int TIMEOUT_DEFAULT = 1000;

  localparam logic [2:0] PIN_DIGITS = 3'd4;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_ENTER     = 4'hB;
  localparam logic [3:0] KEY_CANCEL    = 4'hC;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_CHECK   = 3'd2;
  localparam logic [2:0] ST_DONE    = 3'd3;
  localparam logic [2:0] ST_ABORTED = 3'd4;

  // Slot 0 is the first digit typed and lives in the most significant nibble.
  function automatic logic [15:0] place_digit(input logic [15:0] pin_buf,
                                              input logic [2:0]  slot,
                                              input logic [3:0]  digit);
    logic [15:0] result;
    result = pin_buf;
    case (slot)
      3'd0:    result[15:12] = digit;
      3'd1:    result[11:8]  = digit;
      3'd2:    result[7:4]   = digit;
      3'd3:    result[3:0]   = digit;
      default: result = pin_buf;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/atm_key_timer.sv
// Clearable keypad inactivity counter; raises timeout combinationally on the
// cycle whose closing edge would be the TIMEOUT_CYCLES-th idle edge.
module atm_key_timer #(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  // Saturates at LIMIT so the counter can never wrap while enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + TW'(1);
    end
  end

  assign timeout = en && !clr && (count == LIMIT);

endmodule

// File: rtl/atm_pin_entry.sv
// ATM keypad PIN entry: collects four BCD digits after card insertion,
// compares against the card's reference PIN and reports a held verdict.
module atm_pin_entry
  import atm_pin_entry_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        card_present,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] stored_pin,
  output logic [15:0] pin_input,
  output logic [2:0]  digit_count,
  output logic        pin_valid,
  output logic        correct_pin,
  output logic        pin_error,
  output logic        abort,
  output logic        busy,
  output logic [2:0]  fsm_state
);

  logic [2:0] state;
  logic       is_digit;
  logic       key_accept;
  logic       timer_en;
  logic       timer_clr;
  logic       timeout;

  // Reserved codes (0xD-0xF) are not "accepted" and so do not reset the timer.
  assign is_digit   = (key_code <= KEY_DIGIT_MAX);
  assign key_accept = key_valid && (key_code <= KEY_CANCEL);
  assign timer_en   = (state == ST_COLLECT);
  assign timer_clr  = !card_present || (state != ST_COLLECT) || key_accept;
  assign fsm_state  = state;

  atm_key_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_key_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (timer_en),
    .clr    (timer_clr),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pin_input   <= '0;
      digit_count <= '0;
      pin_valid   <= 1'b0;
      correct_pin <= 1'b0;
      pin_error   <= 1'b0;
      abort       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pin_valid <= 1'b0;
      pin_error <= 1'b0;
      abort     <= 1'b0;
      // Card removal wins over everything, including a key on the same edge.
      if (!card_present) begin
        state       <= ST_IDLE;
        pin_input   <= '0;
        digit_count <= '0;
        correct_pin <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state       <= ST_COLLECT;
            pin_input   <= '0;
            digit_count <= '0;
            correct_pin <= 1'b0;
            busy        <= 1'b1;
          end
          ST_COLLECT: begin
            if (key_accept) begin
              if (is_digit) begin
                if (digit_count < PIN_DIGITS) begin
                  pin_input   <= place_digit(pin_input, digit_count, key_code);
                  digit_count <= digit_count + 3'd1;
                end
              end else if (key_code == KEY_CLEAR) begin
                pin_input   <= '0;
                digit_count <= '0;
              end else if (key_code == KEY_ENTER) begin
                if (digit_count == PIN_DIGITS) begin
                  state <= ST_CHECK;
                end else begin
                  pin_error   <= 1'b1;
                  pin_input   <= '0;
                  digit_count <= '0;
                end
              end else begin
                abort       <= 1'b1;
                state       <= ST_ABORTED;
                pin_input   <= '0;
                digit_count <= '0;
                busy        <= 1'b0;
              end
            end else if (timeout) begin
              abort       <= 1'b1;
              state       <= ST_ABORTED;
              pin_input   <= '0;
              digit_count <= '0;
              busy        <= 1'b0;
            end
          end
          ST_CHECK: begin
            correct_pin <= (pin_input == stored_pin);
            pin_valid   <= 1'b1;
            state       <= ST_DONE;
            busy        <= 1'b0;
          end
          ST_DONE: begin
            busy <= 1'b0;
          end
          ST_ABORTED: begin
            correct_pin <= 1'b0;
            busy        <= 1'b0;
          end
          default: begin
            state       <= ST_IDLE;
            pin_input   <= '0;
            digit_count <= '0;
            correct_pin <= 1'b0;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_atm_pin_entry.sv
// Bench for atm_pin_entry: scenario tasks with inline checks plus a pulse
// scoreboard fed with expected events whenever a terminating key is driven.
module tb_atm_pin_entry;
  import atm_pin_entry_pkg::*;

  localparam int TMO = 16;
  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_ERROR = 2'd2;
  localparam logic [1:0] EV_ABORT = 2'd3;

  logic        clk;
  logic        reset_n;
  logic        card_present;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] stored_pin;
  logic [15:0] pin_input;
  logic [2:0]  digit_count;
  logic        pin_valid;
  logic        correct_pin;
  logic        pin_error;
  logic        abort;
  logic        busy;
  logic [2:0]  fsm_state;

  int tests_run = 0;
  int fails = 0;

  // Entry format: {kind[1:0], correct_pin, pin_input[15:0]}
  logic [18:0] exp_q[$];

  atm_pin_entry #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .card_present(card_present),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .stored_pin  (stored_pin),
    .pin_input   (pin_input),
    .digit_count (digit_count),
    .pin_valid   (pin_valid),
    .correct_pin (correct_pin),
    .pin_error   (pin_error),
    .abort       (abort),
    .busy        (busy),
    .fsm_state   (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  logic [2:0] prev_pulses = 3'b000;
  always @(negedge clk) begin
    logic [2:0]  pulses;
    logic [1:0]  kind;
    logic [18:0] exp_ev;
    pulses = {pin_valid, pin_error, abort};
    if (reset_n && (pulses != 3'b000)) begin
      tests_run++;
      if ($countones(pulses) > 1) begin
        fails++;
        $display("FAIL pulse_exclusive: got %b expected one-hot", pulses);
      end
      tests_run++;
      if ((pulses & prev_pulses) != 3'b000) begin
        fails++;
        $display("FAIL pulse_width: got %b after %b expected single-cycle", pulses, prev_pulses);
      end
      kind = pin_valid ? EV_VALID : (pin_error ? EV_ERROR : EV_ABORT);
      tests_run++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d expected none", kind);
      end else begin
        exp_ev = exp_q.pop_front();
        if (exp_ev[18:17] !== kind) begin
          fails++;
          $display("FAIL event_kind: got %0d expected %0d", kind, exp_ev[18:17]);
        end else if (kind == EV_VALID) begin
          tests_run++;
          if ({correct_pin, pin_input} !== exp_ev[16:0]) begin
            fails++;
            $display("FAIL verdict: got %b/%h expected %b/%h",
                     correct_pin, pin_input, exp_ev[16], exp_ev[15:0]);
          end
        end
      end
    end
    prev_pulses = pulses;
  end

  // ---------------- drivers ----------------
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic card_in();
    @(negedge clk);
    card_present = 1'b1;
    @(negedge clk);
  endtask

  task automatic card_out();
    @(negedge clk);
    card_present = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n      = 1'b0;
    card_present = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    stored_pin   = 16'h0000;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state}
        !== {16'h0, 3'd0, 5'b0, ST_IDLE}) begin
      fails++;
      $display("FAIL reset_state: got %h/%0d/%b%b%b%b%b/%0d expected all zero, IDLE",
               pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state);
    end
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (fsm_state !== ST_IDLE) begin
      fails++;
      $display("FAIL idle_without_card: got state %0d expected %0d", fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_correct_pin();
    stored_pin = 16'h1234;
    card_in();
    tests_run++;
    if ({busy, fsm_state} !== {1'b1, ST_COLLECT}) begin
      fails++;
      $display("FAIL card_insert: got busy %b state %0d expected 1/%0d", busy, fsm_state, ST_COLLECT);
    end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    tests_run++;
    if ({pin_input, digit_count} !== {16'h1234, 3'd4}) begin
      fails++;
      $display("FAIL capture_1234: got %h/%0d expected 1234/4", pin_input, digit_count);
    end
    exp_q.push_back({EV_VALID, 1'b1, 16'h1234});
    press(KEY_ENTER);
    tests_run++;
    if ({pin_valid, busy, fsm_state} !== {1'b0, 1'b1, ST_CHECK}) begin
      fails++;
      $display("FAIL check_cycle: got pv %b busy %b state %0d expected 0/1/%0d",
               pin_valid, busy, fsm_state, ST_CHECK);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({pin_valid, correct_pin, busy, fsm_state} !== {1'b1, 1'b1, 1'b0, ST_DONE}) begin
      fails++;
      $display("FAIL verdict_timing: got pv %b cp %b busy %b state %0d expected 1/1/0/%0d",
               pin_valid, correct_pin, busy, fsm_state, ST_DONE);
    end
    @(posedge clk); #1;
    tests_run++;
    if ({pin_valid, correct_pin} !== 2'b01) begin
      fails++;
      $display("FAIL verdict_hold: got pv %b cp %b expected 0/1", pin_valid, correct_pin);
    end
    press(4'h5);
    press(KEY_CLEAR);
    tests_run++;
    if ({pin_input, correct_pin, fsm_state} !== {16'h1234, 1'b1, ST_DONE}) begin
      fails++;
      $display("FAIL done_ignores_keys: got %h/%b/%0d expected 1234/1/%0d",
               pin_input, correct_pin, fsm_state, ST_DONE);
    end
    card_out();
  endtask

  task automatic test_wrong_pin();
    stored_pin = 16'h1234;
    card_in();
    press(4'h1); press(4'h2); press(4'h3); press(4'h5);
    exp_q.push_back({EV_VALID, 1'b0, 16'h1235});
    press(KEY_ENTER);
    @(posedge clk); #1;
    tests_run++;
    if ({pin_valid, correct_pin, pin_input} !== {1'b1, 1'b0, 16'h1235}) begin
      fails++;
      $display("FAIL wrong_pin: got pv %b cp %b %h expected 1/0/1235", pin_valid, correct_pin, pin_input);
    end
    card_out();
    tests_run++;
    if ({pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state}
        !== {16'h0, 3'd0, 5'b0, ST_IDLE}) begin
      fails++;
      $display("FAIL card_removal: got %h/%0d/%b%b%b%b%b/%0d expected all zero, IDLE",
               pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state);
    end
  endtask

  task automatic test_short_enter();
    stored_pin = 16'h1234;
    card_in();
    press(4'h9); press(4'h8);
    exp_q.push_back({EV_ERROR, 17'h0});
    press(KEY_ENTER);
    tests_run++;
    if ({pin_input, digit_count, busy, fsm_state} !== {16'h0, 3'd0, 1'b1, ST_COLLECT}) begin
      fails++;
      $display("FAIL short_enter: got %h/%0d busy %b state %0d expected 0/0/1/%0d",
               pin_input, digit_count, busy, fsm_state, ST_COLLECT);
    end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    tests_run++;
    if ({pin_input, digit_count} !== {16'h1234, 3'd4}) begin
      fails++;
      $display("FAIL fifth_digit: got %h/%0d expected 1234/4", pin_input, digit_count);
    end
    exp_q.push_back({EV_VALID, 1'b1, 16'h1234});
    press(KEY_ENTER);
    repeat (2) @(negedge clk);
    tests_run++;
    if (correct_pin !== 1'b1) begin
      fails++;
      $display("FAIL retry_verdict: got %b expected 1", correct_pin);
    end
    card_out();
  endtask

  task automatic test_timeout();
    card_in();
    press(4'h7);
    exp_q.push_back({EV_ABORT, 17'h0});
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (abort !== 1'(i == TMO)) begin
        fails++;
        $display("FAIL timeout_edge_%0d: got abort %b expected %b", i, abort, (i == TMO));
      end
    end
    tests_run++;
    if ({pin_input, digit_count, busy, fsm_state} !== {16'h0, 3'd0, 1'b0, ST_ABORTED}) begin
      fails++;
      $display("FAIL timeout_state: got %h/%0d busy %b state %0d expected 0/0/0/%0d",
               pin_input, digit_count, busy, fsm_state, ST_ABORTED);
    end
    press(4'h1); press(KEY_ENTER);
    repeat (TMO + 2) @(negedge clk);
    tests_run++;
    if ({pin_input, digit_count, correct_pin, fsm_state} !== {16'h0, 3'd0, 1'b0, ST_ABORTED}) begin
      fails++;
      $display("FAIL aborted_ignores_keys: got %h/%0d/%b/%0d expected 0/0/0/%0d",
               pin_input, digit_count, correct_pin, fsm_state, ST_ABORTED);
    end
    card_out();
  endtask

  task automatic test_clear_and_cancel();
    stored_pin = 16'h5678;
    card_in();
    press(4'h1); press(4'h2); press(KEY_CLEAR);
    tests_run++;
    if ({pin_input, digit_count, fsm_state} !== {16'h0, 3'd0, ST_COLLECT}) begin
      fails++;
      $display("FAIL clear_key: got %h/%0d state %0d expected 0/0/%0d",
               pin_input, digit_count, fsm_state, ST_COLLECT);
    end
    press(4'h5); press(4'h6); press(4'h7); press(4'h8);
    exp_q.push_back({EV_VALID, 1'b1, 16'h5678});
    press(KEY_ENTER);
    repeat (2) @(negedge clk);
    tests_run++;
    if ({correct_pin, pin_input} !== {1'b1, 16'h5678}) begin
      fails++;
      $display("FAIL clear_verdict: got %b/%h expected 1/5678", correct_pin, pin_input);
    end
    card_out();
    card_in();
    press(4'h3);
    exp_q.push_back({EV_ABORT, 17'h0});
    press(KEY_CANCEL);
    tests_run++;
    if ({abort, busy, pin_input, fsm_state} !== {1'b1, 1'b0, 16'h0, ST_ABORTED}) begin
      fails++;
      $display("FAIL cancel: got abort %b busy %b %h state %0d expected 1/0/0/%0d",
               abort, busy, pin_input, fsm_state, ST_ABORTED);
    end
    card_out();
  endtask

  task automatic test_reserved_keys();
    stored_pin = 16'h1234;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'h3;
    @(negedge clk);
    key_valid = 1'b0;
    tests_run++;
    if ({fsm_state, digit_count} !== {ST_IDLE, 3'd0}) begin
      fails++;
      $display("FAIL idle_key: got state %0d count %0d expected %0d/0", fsm_state, digit_count, ST_IDLE);
    end
    card_in();
    for (int i = 0; i < 3; i++) begin
      press(4'(4'hD + 4'($urandom_range(0, 2))));
      press(4'(4'hD + 4'($urandom_range(0, 2))));
    end
    press(4'h1); press(4'hF);
    tests_run++;
    if ({pin_input, digit_count, fsm_state} !== {16'h1000, 3'd1, ST_COLLECT}) begin
      fails++;
      $display("FAIL reserved_keys: got %h/%0d state %0d expected 1000/1/%0d",
               pin_input, digit_count, fsm_state, ST_COLLECT);
    end
    card_out();
  endtask

  task automatic test_reset_and_drop();
    stored_pin = 16'h1234;
    card_in();
    press(4'h1); press(4'h2);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state}
        !== {16'h0, 3'd0, 5'b0, ST_IDLE}) begin
      fails++;
      $display("FAIL mid_entry_reset: got %h/%0d/%b%b%b%b%b/%0d expected all zero, IDLE",
               pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({fsm_state, digit_count, pin_input} !== {ST_COLLECT, 3'd0, 16'h0}) begin
      fails++;
      $display("FAIL reset_release: got state %0d %0d/%h expected %0d/0/0",
               fsm_state, digit_count, pin_input, ST_COLLECT);
    end
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    @(negedge clk);
    key_valid    = 1'b1;
    key_code     = KEY_ENTER;
    card_present = 1'b0;
    @(negedge clk);
    key_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state}
        !== {16'h0, 3'd0, 5'b0, ST_IDLE}) begin
      fails++;
      $display("FAIL drop_on_enter: got %h/%0d/%b%b%b%b%b/%0d expected all zero, IDLE",
               pin_input, digit_count, pin_valid, correct_pin, pin_error, abort, busy, fsm_state);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_correct_pin();
    test_wrong_pin();
    test_short_enter();
    test_timeout();
    test_clear_and_cancel();
    test_reserved_keys();
    test_reset_and_drop();
    repeat (2) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_events: got %0d outstanding expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
